// File: rtl/fifo_arb_pkg.sv
// Shared defaults and helpers for the FIFO write arbiter.
// Optional grant statistics are enabled by defining FIFO_ARB_STATS_EN.
package fifo_arb_pkg;

  localparam int unsigned DefDepth = 4;
  localparam int unsigned DefDw    = 4;
  // Width of each per-producer grant counter
  localparam int unsigned StatW    = 8;

  // Credit counter width: must hold 0..depth inclusive
  function automatic int unsigned level_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [PW-1:0] idx,
  output logic          valid
);

  int unsigned cand;

  // Scan N candidates starting at ptr; the first hit wins
  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    cand   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = (32'(ptr) + k) % N;
      if (!valid && req[cand]) begin
        valid        = 1'b1;
        onehot[cand] = 1'b1;
        idx          = PW'(cand);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter with credit tracking in front of a small FIFO.
// Define FIFO_ARB_STATS_EN to enable per-producer saturating grant counters.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned DW    = DefDw,
  parameter int unsigned DEPTH = DefDepth
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*DW-1:0]        req_data,
  output logic [NREQ-1:0]           gnt,
  output logic                      fifo_write,
  output logic [DW-1:0]             fifo_data,
  input  logic                      rd_req,
  output logic                      fifo_read,
  output logic [level_w(DEPTH)-1:0] level,
  output logic [NREQ*StatW-1:0]     stat_cnt
);

  localparam int unsigned LW = level_w(DEPTH);
  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            wr_q, wr_d;
  logic [DW-1:0]   data_q, data_d;
  logic            rd_q, rd_d;
  logic [LW-1:0]   level_q, level_d;
  logic [PW-1:0]   ptr_q, ptr_d;

  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] win_oh;
  logic [PW-1:0]   win_idx;
  logic            win_valid;

  // A producer granted this cycle is masked so its next word waits a cycle;
  // no writes are admitted once the credits are exhausted
  always_comb begin
    elig = req & ~gnt_q & {NREQ{level_q < LW'(DEPTH)}};
  end

  rr_pick #(
    .N  (NREQ),
    .PW (PW)
  ) u_rr_pick (
    .req    (elig),
    .ptr    (ptr_q),
    .onehot (win_oh),
    .idx    (win_idx),
    .valid  (win_valid)
  );

  // Next-state: grant/write strobe, read strobe, pointer advance and credit update
  always_comb begin
    gnt_d   = '0;
    wr_d    = 1'b0;
    data_d  = '0;
    rd_d    = 1'b0;
    ptr_d   = ptr_q;
    level_d = level_q;
    if (win_valid) begin
      gnt_d  = win_oh;
      wr_d   = 1'b1;
      data_d = req_data[win_idx*DW +: DW];
      ptr_d  = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
    end
    // Reads with no credits are dropped rather than queued
    rd_d = rd_req && (level_q != '0);
    case ({wr_d, rd_d})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q   <= '0;
      wr_q    <= 1'b0;
      data_q  <= '0;
      rd_q    <= 1'b0;
      level_q <= '0;
      ptr_q   <= '0;
    end else begin
      gnt_q   <= gnt_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
      level_q <= level_d;
      ptr_q   <= ptr_d;
    end
  end

  assign gnt        = gnt_q;
  assign fifo_write = wr_q;
  assign fifo_data  = data_q;
  assign fifo_read  = rd_q;
  assign level      = level_q;

`ifdef FIFO_ARB_STATS_EN
  logic [NREQ-1:0][StatW-1:0] stat_q;

  // Count cycles each producer holds a grant, saturating at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_q <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (gnt_q[i] && (stat_q[i] != '1)) begin
          stat_q[i] <= stat_q[i] + StatW'(1);
        end
      end
    end
  end

  assign stat_cnt = stat_q;
`else
  assign stat_cnt = '0;
`endif

endmodule
